// File: rtl/tiny16_pkg.sv
// Shared types and constants for the tiny16 memory arbiter.
package tiny16_pkg;

    // Arbiter/sequencer states: wait for a request, load MAR, then move data.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    // Requester identifiers, also used as the round-robin pointer value.
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    // Cycles from grant to acknowledge: ADDR, DATA, ack.
    localparam int unsigned ACCESS_CYCLES = 3;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: the port not granted last wins a tie.
module rr_pick2 (
    input  logic [1:0] eligible,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    // A lone eligible port always wins; on a tie the pointer decides.
    always_comb begin
        valid  = |eligible;
        winner = eligible[1];
        if (&eligible) begin
            winner = ~last;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU and DMA access to the tiny16 word memory and sequences
// the MAR-load / data-transfer protocol, returning a one-cycle ack.
module mem_arbiter
    import tiny16_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_addr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_in_en,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_out_en,
    input  logic [DATA_W-1:0] mem_out
);

    state_t            state_q;
    logic              last_q;
    logic              gnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [1:0]        eligible;
    logic              pick_valid;
    logic              pick_winner;

    // A port in its ack cycle is masked so a held req is not re-granted.
    assign eligible = {dma_req & ~dma_ack, cpu_req & ~cpu_ack};

    rr_pick2 u_pick (
        .eligible (eligible),
        .last     (last_q),
        .valid    (pick_valid),
        .winner   (pick_winner)
    );

    // Sequencer FSM with latched request fields, pointer and per-port ack/rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= REQ_DMA;
            gnt_q     <= REQ_CPU;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else begin
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_q   <= pick_winner;
                        last_q  <= pick_winner;
                        we_q    <= (pick_winner == REQ_DMA) ? dma_we    : cpu_we;
                        addr_q  <= (pick_winner == REQ_DMA) ? dma_addr  : cpu_addr;
                        wdata_q <= (pick_winner == REQ_DMA) ? dma_wdata : cpu_wdata;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    state_q <= DATA;
                end
                DATA: begin
                    if (!we_q) begin
                        if (gnt_q == REQ_DMA) begin
                            dma_rdata <= mem_out;
                        end else begin
                            cpu_rdata <= mem_out;
                        end
                    end
                    if (gnt_q == REQ_DMA) begin
                        dma_ack <= 1'b1;
                    end else begin
                        cpu_ack <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Memory strobes follow the state; gating with rst blocks MAR loads and
    // writes on any edge where reset is asserted.
    always_comb begin
        mem_addr_en = ~rst & (state_q == ADDR);
        mem_in_en   = ~rst & (state_q == DATA) & we_q;
        mem_out_en  = ~rst & (state_q == DATA) & ~we_q;
        mem_addr    = addr_q;
        mem_in      = wdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level
// reference: ordered memory image, ack timing bounds and per-port read data.
module tb_mem_arbiter;
    import tiny16_pkg::*;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req;
    logic [1:0]    we;
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    logic          cpu_ack, dma_ack;
    logic [DW-1:0] cpu_rdata, dma_rdata;
    logic          mem_addr_en, mem_in_en, mem_out_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_in, mem_out;

    // Memory stub: MAR register and word array.
    logic [AW-1:0] mar;
    logic [DW-1:0] mem_array [0:65535];

    // Reference model state.
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] exp_rd [2];
    logic [1:0]    active;
    int            wait_cnt [2];
    logic [AW-1:0] addr_tbl [7];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_addr_en) mar <= mem_addr;
        if (mem_in_en) mem_array[mar] <= mem_in;
    end
    assign mem_out = mem_array[mar];

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (req[0]),
        .cpu_we      (we[0]),
        .cpu_addr    (addr[0]),
        .cpu_wdata   (wdata[0]),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .dma_req     (req[1]),
        .dma_we      (we[1]),
        .dma_addr    (addr[1]),
        .dma_wdata   (wdata[1]),
        .dma_ack     (dma_ack),
        .dma_rdata   (dma_rdata),
        .mem_addr_en (mem_addr_en),
        .mem_addr    (mem_addr),
        .mem_in_en   (mem_in_en),
        .mem_in      (mem_in),
        .mem_out_en  (mem_out_en),
        .mem_out     (mem_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete access on port p, bounded wait for the ack; returns rdata.
    task automatic do_access(input int p, input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, output logic [DW-1:0] rd);
        bit got = 1'b0;
        req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            got = (p == 0) ? cpu_ack : dma_ack;
        end
        check("access_ack_seen", {31'd0, got}, 32'd1);
        rd = (p == 0) ? cpu_rdata : dma_rdata;
        req[p] = 1'b0;
        if (w) ref_mem[a] = d;
        @(negedge clk);
    endtask

    task automatic start_req(input int p);
        req[p]      = 1'b1;
        we[p]       = 1'($urandom_range(1, 0));
        addr[p]     = addr_tbl[$urandom_range(6, 0)];
        wdata[p]    = DW'($urandom);
        active[p]   = 1'b1;
        wait_cnt[p] = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rd;
        logic          ackp;
        logic [DW-1:0] rdp, rdo;

        rst = 1'b1; req = '0; we = '0;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        active = '0;
        addr_tbl[0] = 16'h0005; addr_tbl[1] = 16'h0010; addr_tbl[2] = 16'h0020;
        addr_tbl[3] = 16'h0030; addr_tbl[4] = 16'h0040; addr_tbl[5] = 16'h0041;
        addr_tbl[6] = 16'hFFFF;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        check("rst_dma_ack", {31'd0, dma_ack}, 32'd0);
        check("rst_addr_en", {31'd0, mem_addr_en}, 32'd0);
        check("rst_in_en", {31'd0, mem_in_en}, 32'd0);
        check("rst_out_en", {31'd0, mem_out_en}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_mem_in", {16'd0, mem_in}, 32'd0);
        check("rst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
        check("rst_dma_rdata", {16'd0, dma_rdata}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // CPU write 0x0005 = 0xBEEF with exact protocol timing
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0005; wdata[0] = 16'hBEEF;
        @(negedge clk);
        check("w1_addr_en", {31'd0, mem_addr_en}, 32'd1);
        check("w1_mem_addr", {16'd0, mem_addr}, 32'h0005);
        check("w1_in_en_early", {31'd0, mem_in_en}, 32'd0);
        @(negedge clk);
        check("w1_in_en", {31'd0, mem_in_en}, 32'd1);
        check("w1_mem_in", {16'd0, mem_in}, 32'hBEEF);
        check("w1_addr_en_off", {31'd0, mem_addr_en}, 32'd0);
        check("w1_ack_early", {31'd0, cpu_ack}, 32'd0);
        @(negedge clk);
        check("w1_cpu_ack", {31'd0, cpu_ack}, 32'd1);
        req[0] = 1'b0;
        ref_mem[16'h0005] = 16'hBEEF;
        @(negedge clk);
        check("w1_ack_pulse", {31'd0, cpu_ack}, 32'd0);

        // DMA read-back of 0x0005
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0005;
        @(negedge clk);
        check("r2_mem_addr", {16'd0, mem_addr}, 32'h0005);
        @(negedge clk);
        check("r2_out_en", {31'd0, mem_out_en}, 32'd1);
        check("r2_in_en", {31'd0, mem_in_en}, 32'd0);
        @(negedge clk);
        check("r2_dma_ack", {31'd0, dma_ack}, 32'd1);
        check("r2_dma_rdata", {16'd0, dma_rdata}, 32'hBEEF);
        check("r2_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
        req[1] = 1'b0;
        @(negedge clk);

        // Both held continuously: grants alternate CPU, DMA, acks 3 cycles apart
        req = 2'b11; we = 2'b11;
        addr[0] = 16'h0010; wdata[0] = 16'hC0DE;
        addr[1] = 16'h0020; wdata[1] = 16'hD00D;
        for (int k = 1; k <= 8 * ACCESS_CYCLES; k++) begin
            @(negedge clk);
            check("rr_cpu_ack", {31'd0, cpu_ack}, {31'd0, (k % 6) == 3});
            check("rr_dma_ack", {31'd0, dma_ack}, {31'd0, (k % 6) == 0});
            if ((k % 3) == 1) begin
                check("rr_grant_addr", {16'd0, mem_addr}, ((k % 6) == 1) ? 32'h10 : 32'h20);
            end
        end
        req = 2'b00;
        ref_mem[16'h0010] = 16'hC0DE;
        ref_mem[16'h0020] = 16'hD00D;
        @(negedge clk);

        // CPU holds req for two reads, DMA idle: acks 4 cycles apart
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0010;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("held_cpu_ack", {31'd0, cpu_ack}, {31'd0, k == 3 || k == 7});
            if (k == 3) check("held_rdata", {16'd0, cpu_rdata}, 32'hC0DE);
            if (k == 7) req[0] = 1'b0;
        end

        // Reset during DATA of a CPU write aborts it
        do_access(1, 1'b1, 16'h0030, 16'h1111, rd);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0030; wdata[0] = 16'h2222;
        @(negedge clk);
        check("abort_addr_en", {31'd0, mem_addr_en}, 32'd1);
        @(negedge clk);
        check("abort_in_en_pre", {31'd0, mem_in_en}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_in_en_gated", {31'd0, mem_in_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0; req[0] = 1'b0;
        check("abort_no_ack", {31'd0, cpu_ack}, 32'd0);
        @(negedge clk);
        check("abort_no_ack2", {31'd0, cpu_ack}, 32'd0);
        check("abort_idle", {29'd0, mem_addr_en, mem_in_en, mem_out_en}, 32'd0);
        do_access(1, 1'b0, 16'h0030, 16'h0000, rd);
        check("abort_old_value", {16'd0, rd}, 32'h1111);

        // Address change during ADDR is ignored
        do_access(1, 1'b1, 16'h0040, 16'hAAAA, rd);
        do_access(1, 1'b1, 16'h0041, 16'h5555, rd);
        do_access(1, 1'b1, 16'hFFFF, 16'h7E57, rd);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0040;
        @(negedge clk);
        check("chg_mem_addr", {16'd0, mem_addr}, 32'h0040);
        addr[0] = 16'h0041;
        @(negedge clk);
        check("chg_out_en", {31'd0, mem_out_en}, 32'd1);
        @(negedge clk);
        check("chg_cpu_ack", {31'd0, cpu_ack}, 32'd1);
        check("chg_cpu_rdata", {16'd0, cpu_rdata}, 32'hAAAA);
        req[0] = 1'b0;
        @(negedge clk);
        do_access(0, 1'b0, 16'hFFFF, 16'h0000, rd);
        check("top_addr_rdata", {16'd0, rd}, 32'h7E57);

        // Randomized traffic against the transaction-level model
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                ackp = (p == 0) ? cpu_ack : dma_ack;
                rdp  = (p == 0) ? cpu_rdata : dma_rdata;
                rdo  = (p == 0) ? dma_rdata : cpu_rdata;
                if (ackp) begin
                    check("rnd_ack_expected", {31'd0, active[p]}, 32'd1);
                    if (active[p]) begin
                        check("rnd_min_latency", {31'd0, wait_cnt[p] + 1 >= ACCESS_CYCLES},
                              32'd1);
                        if (we[p]) begin
                            ref_mem[addr[p]] = wdata[p];
                        end else begin
                            check("rnd_rdata", {16'd0, rdp}, {16'd0, ref_mem[addr[p]]});
                            exp_rd[p] = ref_mem[addr[p]];
                        end
                    end
                    check("rnd_other_rdata", {16'd0, rdo}, {16'd0, exp_rd[1-p]});
                    active[p] = 1'b0;
                    req[p]    = 1'b0;
                    if ($urandom_range(1, 0) == 1) start_req(p);
                end else if (active[p]) begin
                    wait_cnt[p]++;
                    check("rnd_wait_bound", {31'd0, wait_cnt[p] <= 7}, 32'd1);
                end else if ($urandom_range(2, 0) == 0) begin
                    start_req(p);
                end
            end
        end
        req = 2'b00;
        repeat (8) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
